hash_byte_packer: RTL and testbench
===================================

// Module: hash_byte_packer
// PURPOSE
//   Upstream feeder for the hasher. Collects a byte stream into 64-bit words
//   with a byte count, and presents each word as {data, data_len} on a
//   valid/ready port. Messages longer than 8 bytes are split into 8-byte
//   chunks. An idle timeout flushes stalled partial words.
// PARAMETERS
//   TIMEOUT   16   idle cycles before a partial word is flushed; 0 = disabled
//   TO_W      16   width of the idle counter; TIMEOUT must be < 2**TO_W
// PORTS
//   clk        in   1   single clock; rising edge
//   reset_n    in   1   asynchronous, active-low reset
//   in_byte    in   8   input data byte
//   in_valid   in   1   in_byte is valid
//   in_last    in   1   in_byte is the final byte of the message
//   in_ready   out  1   packer can accept a byte this cycle
//   flush      in   1   1-cycle pulse: close the current word now, even if 0 bytes
//   data       out  64  packed word; byte k sits in [8k+7:8k]; unused bytes are 0
//   data_len   out  4   valid bytes in data, 0..8
//   out_last   out  1   word ends a message (in_last or flush seen)
//   out_valid  out  1   data/data_len/out_last are valid
//   out_ready  in   1   consumer accepts the word
// BEHAVIOUR
//   - Reset (async assert, sync release): state=FILL, count=0, data=0,
//     data_len=0, out_last=0, out_valid=0, in_ready=1, idle counter=0.
//   - States: FILL and HOLD. in_ready = (state==FILL); out_valid = (state==HOLD).
//   - FILL, byte accepted (in_valid & in_ready):
//     - write the byte at slot count; count++.
//     - If in_last or the new count==8: go to HOLD next cycle with
//       data_len = new count and out_last = in_last.
//     - An 8th byte without in_last gives out_last=0, and the message continues
//       in the next word.
//   - Latency: the closing byte is accepted at edge N; out_valid is high from
//     edge N onward, so the word is visible in the cycle after acceptance.
//   - flush in FILL with no byte accepted: go to HOLD with data_len=count
//     (may be 0) and out_last=1.
//   - flush together with an accepted byte: the byte is packed first, then
//     the word closes with out_last=1.
//   - flush in HOLD is ignored.
//   - Idle timeout: the counter increments each FILL cycle with count>0 and
//     no byte accepted. It clears on any accept and on entering FILL.
//     - When the counter reaches TIMEOUT: go to HOLD with data_len=count and
//       out_last=0.
//     - The timeout never fires when count==0 or when TIMEOUT==0.
//   - HOLD:
//     - data, data_len and out_last stay stable while out_valid & !out_ready.
//     - On out_ready: go to FILL next cycle; count, data and the idle counter
//       clear.
//     - No byte is accepted in the handshake cycle (in_ready=0 throughout HOLD).
//   - in_byte and in_last are don't-care when in_valid=0.
//   - in_valid=1 while in_ready=0 has no effect.
//   - Reset mid-word or mid-HOLD discards the partial or pending word, with
//     no output pulse.
//   - count is 4 bits and never exceeds 8; data_len never exceeds 8.
// TESTING
//   1. Send bytes 11,22,33 with in_last on 33, out_ready=1
//      -> one word: data=64'h0000_0000_0033_2211, data_len=3, out_last=1.
//   2. Send a 10-byte message 01..0A, last on 0A
//      -> word 1: data=64'h0807_0605_0403_0201, len 8, last 0;
//         word 2: data=64'h0A09, len 2, last 1.
//   3. Close a word, hold out_ready=0 for 5 cycles
//      -> out_valid and data stay stable, in_ready=0 throughout;
//         accept resumes the cycle after out_ready.
//   4. flush with count=0
//      -> data=0, data_len=0, out_last=1.
//      flush together with the byte AB -> data=64'hAB, len 1, last 1.
//   5. TIMEOUT=16: send 2 bytes, then idle
//      -> out_valid rises after 16 idle cycles with len 2, last 0.
//      With TIMEOUT=0 -> no flush after 100 idle cycles.
//   6. Assert reset_n=0 with 5 bytes buffered, then release and send 1 byte
//      with in_last -> data_len=1, no stale bytes in data.

Source files
------------

// File: rtl/hash_byte_packer.sv
// Packs a byte stream into 64-bit words with a byte count for the hasher.
// A word closes on in_last, a full 8 bytes, a flush pulse, or an idle timeout.
module hash_byte_packer #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        flush,
  output logic [63:0] data,
  output logic [3:0]  data_len,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              TO_EN   = (TIMEOUT > 0);

  state_e            state_q;
  logic [3:0]        count_q;
  logic [3:0]        count_d;
  logic [63:0]       data_q;
  logic [3:0]        len_q;
  logic              last_q;
  logic [TO_W-1:0]   idle_q;
  logic              accept;
  logic              close_on_byte;
  logic              timeout_hit;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign data      = data_q;
  assign data_len  = len_q;
  assign out_last  = last_q;

  assign accept        = in_valid & in_ready;
  assign count_d       = count_q + 4'd1;
  assign close_on_byte = in_last | flush | (count_d == 4'd8);
  // Firing on the edge that ends the TIMEOUT-th idle cycle, not one later.
  assign timeout_hit   = TO_EN && (count_q != 4'd0) && (idle_q == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      count_q <= 4'd0;
      data_q  <= 64'd0;
      len_q   <= 4'd0;
      last_q  <= 1'b0;
      idle_q  <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            // count_q is always < 8 in FILL, so the low 3 bits select the slot.
            data_q[{count_q[2:0], 3'b000} +: 8] <= in_byte;
            count_q <= count_d;
            idle_q  <= '0;
            if (close_on_byte) begin
              state_q <= HOLD;
              len_q   <= count_d;
              last_q  <= in_last | flush;
            end
          end else if (flush) begin
            state_q <= HOLD;
            len_q   <= count_q;
            last_q  <= 1'b1;
            idle_q  <= '0;
          end else if (timeout_hit) begin
            state_q <= HOLD;
            len_q   <= count_q;
            last_q  <= 1'b0;
            idle_q  <= '0;
          end else if (count_q != 4'd0) begin
            idle_q  <= idle_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= FILL;
            count_q <= 4'd0;
            data_q  <= 64'd0;
            idle_q  <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_byte_packer.sv
// Directed bench for hash_byte_packer: one instance with TIMEOUT=16 and one
// with the timeout disabled, both driven from the same stimulus.
module tb_hash_byte_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_byte;
  logic        in_valid, in_last, flush, out_ready;
  logic        in_ready, out_last, out_valid;
  logic [63:0] data;
  logic [3:0]  data_len;
  logic        in_ready0, out_last0, out_valid0;
  logic [63:0] data0;
  logic [3:0]  data_len0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hash_byte_packer #(.TIMEOUT(16), .TO_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .flush(flush), .data(data),
    .data_len(data_len), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready));

  hash_byte_packer #(.TIMEOUT(0), .TO_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready0), .flush(flush), .data(data0),
    .data_len(data_len0), .out_last(out_last0), .out_valid(out_valid0),
    .out_ready(out_ready));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    in_valid = 1'b1; in_byte = b; in_last = last;
    step();
    in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [63:0] d, input logic [3:0] l, input logic lst);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  data, d);
    chk({tag, "_len"},   64'(data_len), 64'(l));
    chk({tag, "_last"},  64'(out_last), 64'(lst));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ovalid"}, 64'(out_valid), 64'd0);
    chk({tag, "_iready"}, 64'(in_ready), 64'd1);
    chk({tag, "_data"},   data, 64'd0);
    chk({tag, "_len"},    64'(data_len), 64'd0);
    chk({tag, "_last"},   64'(out_last), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_reset("rst");
    reset_n = 1'b1;
    step();

    // 1: three-byte message
    out_ready = 1'b1;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b1);
    chk_word("t1", 64'h0000_0000_0033_2211, 4'd3, 1'b1);
    step();
    chk("t1_iready_after", 64'(in_ready), 64'd1);
    chk("t1_ovalid_after", 64'(out_valid), 64'd0);

    // 2: ten-byte message splits into 8 + 2
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    chk_word("t2w1", 64'h0807_0605_0403_0201, 4'd8, 1'b0);
    step();
    send(8'h09, 1'b0); send(8'h0A, 1'b1);
    chk_word("t2w2", 64'h0000_0000_0000_0A09, 4'd2, 1'b1);
    step();
    out_ready = 1'b0;

    // 3: backpressure; bytes offered during HOLD must be ignored
    send(8'h5A, 1'b1);
    in_valid = 1'b1; in_byte = 8'hEE; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_data", data, 64'h5A);
      chk("t3_hold_iready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk_word("t3_flush_in_hold", 64'h5A, 4'd1, 1'b1);
    handshake();
    chk("t3_resume_iready", 64'(in_ready), 64'd1);
    send(8'h77, 1'b1);
    chk_word("t3_next", 64'h77, 4'd1, 1'b1);
    handshake();

    // 4: flush with empty word, then flush together with a byte
    flush = 1'b1; step(); flush = 1'b0;
    chk_word("t4_empty", 64'd0, 4'd0, 1'b1);
    handshake();
    flush = 1'b1; send(8'hAB, 1'b0); flush = 1'b0;
    chk_word("t4_byte", 64'hAB, 4'd1, 1'b1);
    handshake();

    // 5: idle timeout fires after 16 idle cycles; disabled instance never does
    send(8'hC1, 1'b0); send(8'hC2, 1'b0);
    for (int i = 0; i < 15; i++) step();
    chk("t5_before_to", 64'(out_valid), 64'd0);
    step();
    chk_word("t5_to", 64'h0000_0000_0000_C2C1, 4'd2, 1'b0);
    for (int i = 0; i < 84; i++) step();
    chk("t5_to0_valid", 64'(out_valid0), 64'd0);
    chk("t5_to0_iready", 64'(in_ready0), 64'd1);
    handshake();
    chk("t5_after_hs", 64'(out_valid), 64'd0);
    // dut0 still holds C1 C2; close it so both instances start test 6 aligned
    flush = 1'b1; step(); flush = 1'b0;
    chk("t5_to0_flush_data", data0, 64'h0000_0000_0000_C2C1);
    handshake();

    // 6: reset mid-word discards buffered bytes
    for (int i = 0; i < 5; i++) send(8'hF0 + 8'(i), 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t6_async_ovalid", 64'(out_valid), 64'd0);
    chk("t6_async_data", data, 64'd0);
    @(negedge clk);
    chk_reset("t6_rst");
    reset_n = 1'b1;
    step();
    send(8'h99, 1'b1);
    chk_word("t6_word", 64'h99, 4'd1, 1'b1);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
